// File: rtl/sm83_irq_pkg.sv
// Shared definitions for the SM83 interrupt dispatch block.
//   irq_state_t        : dispatch sequencer states
//   *_DEFAULT          : default source count and vector layout
//   vec_of(k, ...)     : service address of source k
package sm83_irq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StW1,
    StW2,
    StPushHi,
    StPushLo,
    StJump
  } irq_state_t;

  localparam int unsigned N_IRQ_DEFAULT    = 5;
  localparam logic [15:0] VEC_BASE_DEFAULT = 16'h0040;
  localparam int unsigned VEC_STEP_DEFAULT = 8;

  // Computed in 16 bits; the caller guarantees k*step fits in a byte.
  function automatic logic [15:0] vec_of(input int unsigned k,
                                         input logic [15:0] base = VEC_BASE_DEFAULT,
                                         input int unsigned step = VEC_STEP_DEFAULT);
    return base + 16'(k * step);
  endfunction

endpackage

// File: rtl/sm83_irq_prio.sv
// Combinational lowest-set-bit priority encoder (bit 0 wins).
//   req_i   : request vector
//   grant_o : one-hot grant of the lowest set bit (0 when no request)
//   idx_o   : index of the granted bit (0 when no request)
//   none_o  : no request bit is set
module sm83_irq_prio #(
  parameter int unsigned N_IRQ = 5,
  parameter int unsigned IdxW  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic [N_IRQ-1:0] grant_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             none_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    // Scan from the top down so the lowest set bit is the last writer.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IdxW'(i);
      end
    end
    none_o = ~|req_i;
  end

endmodule

// File: rtl/sm83_irq_dispatch.sv
// SM83 interrupt-service sequencer: IDLE -> W1 -> W2 -> PUSH_HI -> PUSH_LO -> JUMP.
//   clk, reset     : clock, synchronous active-high reset
//   mcyc_en        : M-cycle advance strobe; state moves only when high
//   irq_pending    : gated IF & IE vector from the latch array
//   ime            : master interrupt enable (checked only at entry)
//   insn_boundary  : sequencer is at an opcode fetch
//   halted         : CPU is in HALT
//   busy           : dispatch in progress
//   wake           : HALT wake-up, independent of ime
//   ime_clr        : one-clk pulse after entry
//   pc_dec         : W1 decode, undo prefetch increment
//   push_hi/lo     : PUSH_HI / PUSH_LO decodes
//   jump           : JUMP decode, load PC from vector
//   vector         : latched service address
//   irq_ack        : one-hot one-clk acknowledge of the serviced source
module sm83_irq_dispatch
  import sm83_irq_pkg::*;
#(
  parameter int unsigned N_IRQ    = N_IRQ_DEFAULT,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT,
  parameter int unsigned VEC_STEP = VEC_STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mcyc_en,
  input  logic [N_IRQ-1:0] irq_pending,
  input  logic             ime,
  input  logic             insn_boundary,
  input  logic             halted,
  output logic             busy,
  output logic             wake,
  output logic             ime_clr,
  output logic             pc_dec,
  output logic             push_hi,
  output logic             push_lo,
  output logic             jump,
  output logic [15:0]      vector,
  output logic [N_IRQ-1:0] irq_ack
);

  localparam int unsigned IdxW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  if ((N_IRQ - 1) * VEC_STEP > 255) begin : g_vec_range_err
    $error("sm83_irq_dispatch: (N_IRQ-1)*VEC_STEP exceeds 8'hFF");
  end

  irq_state_t       state_q, state_d;
  logic [15:0]      vector_q, vector_d;
  logic [N_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic             ime_clr_q, ime_clr_d;

  logic [N_IRQ-1:0] prio_grant;
  logic [IdxW-1:0]  prio_idx;
  logic             prio_none;
  int unsigned      prio_k;

  sm83_irq_prio #(
    .N_IRQ (N_IRQ),
    .IdxW  (IdxW)
  ) u_prio (
    .req_i   (irq_pending),
    .grant_o (prio_grant),
    .idx_o   (prio_idx),
    .none_o  (prio_none)
  );

  assign prio_k = 32'(prio_idx);

  always_comb begin
    state_d   = state_q;
    vector_d  = vector_q;
    irq_ack_d = '0;
    ime_clr_d = 1'b0;
    if (mcyc_en) begin
      unique case (state_q)
        StIdle: begin
          if (insn_boundary && ime && |irq_pending) begin
            state_d   = StW1;
            ime_clr_d = 1'b1;
          end
        end
        StW1:     state_d = StW2;
        StW2:     state_d = StPushHi;
        StPushHi: begin
          // Late priority sampling; a withdrawn request still completes with vector 0.
          state_d   = StPushLo;
          vector_d  = prio_none ? 16'h0000 : vec_of(prio_k, VEC_BASE, VEC_STEP);
          irq_ack_d = prio_grant;
        end
        StPushLo: state_d = StJump;
        StJump:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      vector_q  <= 16'h0000;
      irq_ack_q <= '0;
      ime_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vector_q  <= vector_d;
      irq_ack_q <= irq_ack_d;
      ime_clr_q <= ime_clr_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign pc_dec  = (state_q == StW1);
  assign push_hi = (state_q == StPushHi);
  assign push_lo = (state_q == StPushLo);
  assign jump    = (state_q == StJump);
  assign vector  = vector_q;
  assign irq_ack = irq_ack_q;
  assign ime_clr = ime_clr_q;
  assign wake    = halted & |irq_pending;

endmodule

// File: tb/tb_sm83_irq_dispatch.sv
module tb_sm83_irq_dispatch;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset, mcyc_en, ime, insn_boundary, halted;
  logic [N-1:0] irq_pending;
  logic         busy, wake, ime_clr, pc_dec, push_hi, push_lo, jump;
  logic [15:0]  vector;
  logic [N-1:0] irq_ack;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: dispatch position 0 = idle, 1..5 = W1, W2, PUSH_HI, PUSH_LO, JUMP.
  int           m_pos = 0;
  logic [15:0]  m_vec = 16'h0000;
  logic [N-1:0] m_ack = '0;
  logic         m_clr = 1'b0;

  sm83_irq_dispatch dut (
    .clk           (clk),
    .reset         (reset),
    .mcyc_en       (mcyc_en),
    .irq_pending   (irq_pending),
    .ime           (ime),
    .insn_boundary (insn_boundary),
    .halted        (halted),
    .busy          (busy),
    .wake          (wake),
    .ime_clr       (ime_clr),
    .pc_dec        (pc_dec),
    .push_hi       (push_hi),
    .push_lo       (push_lo),
    .jump          (jump),
    .vector        (vector),
    .irq_ack       (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int k;
    m_ack = '0;
    m_clr = 1'b0;
    if (reset) begin
      m_pos = 0;
      m_vec = 16'h0000;
    end else if (mcyc_en) begin
      if (m_pos == 0) begin
        if (insn_boundary && ime && irq_pending != 0) begin
          m_pos = 1;
          m_clr = 1'b1;
        end
      end else if (m_pos == 3) begin
        k = -1;
        for (int i = 0; i < N; i++) if (k < 0 && irq_pending[i]) k = i;
        if (k < 0) m_vec = 16'h0000;
        else begin
          m_vec = 16'h0040 + 16'(k * 8);
          m_ack = N'(1) << k;
        end
        m_pos = 4;
      end else if (m_pos == 5) m_pos = 0;
      else m_pos = m_pos + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_pos != 0));
      chk("pc_dec", 32'(pc_dec), 32'(m_pos == 1));
      chk("push_hi", 32'(push_hi), 32'(m_pos == 3));
      chk("push_lo", 32'(push_lo), 32'(m_pos == 4));
      chk("jump", 32'(jump), 32'(m_pos == 5));
      chk("vector", 32'(vector), 32'(m_vec));
      chk("irq_ack", 32'(irq_ack), 32'(m_ack));
      chk("ime_clr", 32'(ime_clr), 32'(m_clr));
      chk("wake", 32'(wake), 32'(halted & (|irq_pending)));
      chk("ack_clr_excl", 32'((|irq_ack) & ime_clr), 32'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Fire a dispatch request on the next edge, then drop the boundary.
  task automatic enter(input logic [N-1:0] pend);
    irq_pending = pend; ime = 1'b1; insn_boundary = 1'b1; mcyc_en = 1'b1;
    tick();
    insn_boundary = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mcyc_en = 1'b0; ime = 1'b0; insn_boundary = 1'b0; halted = 1'b0;
    irq_pending = '0;
    tick(); tick();
    chk_en = 1'b1;
    reset = 1'b0;
    chk("rst_vector", 32'(vector), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(irq_ack), 32'h0);
    tick();

    // Single source 2.
    enter(5'b00100);
    chk("s1_ime_clr", 32'(ime_clr), 32'h1);
    chk("s1_pc_dec", 32'(pc_dec), 32'h1);
    tick();
    chk("s1_ime_clr_gone", 32'(ime_clr), 32'h0);
    tick();
    chk("s1_push_hi", 32'(push_hi), 32'h1);
    tick();
    chk("s1_vector", 32'(vector), 32'h0050);
    chk("s1_ack", 32'(irq_ack), 32'b00100);
    tick();
    chk("s1_jump", 32'(jump), 32'h1);
    chk("s1_ack_gone", 32'(irq_ack), 32'h0);
    tick();
    chk("s1_idle", 32'(busy), 32'h0);

    // Higher-priority source raised during PUSH_HI.
    enter(5'b10000);
    tick(); tick();
    irq_pending = 5'b10010;
    tick();
    chk("pc_vector", 32'(vector), 32'h0048);
    chk("pc_ack", 32'(irq_ack), 32'b00010);
    tick(); tick();

    // Request withdrawn during PUSH_HI.
    enter(5'b00001);
    tick(); tick();
    irq_pending = '0;
    tick();
    chk("cx_vector", 32'(vector), 32'h0000);
    chk("cx_ack", 32'(irq_ack), 32'h0);
    tick();
    chk("cx_jump", 32'(jump), 32'h1);
    tick();

    // IME off in HALT: wake only.
    ime = 1'b0; halted = 1'b1; irq_pending = 5'b01000; insn_boundary = 1'b1;
    #1;
    chk("halt_wake", 32'(wake), 32'h1);
    tick(); tick();
    chk("halt_busy", 32'(busy), 32'h0);
    chk("halt_clr", 32'(ime_clr), 32'h0);
    halted = 1'b0; insn_boundary = 1'b0;

    // Reset while in PUSH_LO.
    enter(5'b00010);
    tick(); tick(); tick();
    chk("rl_in_push_lo", 32'(push_lo), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rl_busy", 32'(busy), 32'h0);
    chk("rl_vector", 32'(vector), 32'h0);
    chk("rl_jump", 32'(jump), 32'h0);
    chk("rl_ack", 32'(irq_ack), 32'h0);
    tick();

    // Random mcyc_en duty with source 0 pending.
    begin
      bit started = 1'b0;
      bit done = 1'b0;
      irq_pending = 5'b00001; ime = 1'b1; insn_boundary = 1'b1;
      for (int c = 0; c < 300 && !done; c++) begin
        mcyc_en = 1'($urandom_range(0, 2) == 0);
        tick();
        if (m_pos != 0) begin
          started = 1'b1;
          insn_boundary = 1'b0;
        end else if (started) done = 1'b1;
      end
      chk("gap_complete", 32'(done), 32'h1);
      chk("gap_vector", 32'(vector), 32'h0040);
    end

    // Fully random traffic.
    for (int c = 0; c < 4000; c++) begin
      reset         = 1'($urandom_range(0, 99) == 0);
      mcyc_en       = 1'($urandom_range(0, 3) != 0);
      ime           = 1'($urandom_range(0, 3) != 0);
      insn_boundary = 1'($urandom_range(0, 2) == 0);
      halted        = 1'($urandom_range(0, 7) == 0);
      irq_pending   = ($urandom_range(0, 2) == 0) ? N'(0) : N'($urandom);
      tick();
    end

    reset = 1'b0; mcyc_en = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
